// File: rtl/ram8_clr.sv
// Eight-word register file with a sequential clear engine.
// A clr request zeroes one register per cycle over eight cycles while busy is high.
module ram8_clr #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic [2:0]       address,
  input  logic             clr,
  output logic [WIDTH-1:0] out,
  output logic             busy
);

  localparam int unsigned NREGS = 8;
  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    CLEAR = 2'b01
  } state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic               busy_q;
  logic [WIDTH-1:0]   mem_q [NREGS];
  logic [NREGS-1:0]   load_en;

  // One-hot write enables decoded from address.
  always_comb begin
    load_en          = '0;
    load_en[address] = load;
  end

  assign cnt_d = cnt_q + CNT_W'(1);

  // Single-process FSM: storage, clear counter and busy flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (clr) begin
            // clr wins over a simultaneous load
            state_q <= CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end else begin
            for (int i = 0; i < NREGS; i++) begin
              if (load_en[i]) mem_q[i] <= in;
            end
          end
        end
        CLEAR: begin
          mem_q[cnt_q] <= '0;
          cnt_q        <= cnt_d;
          if (cnt_q == CNT_W'(NREGS - 1)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign out  = mem_q[address];
  assign busy = busy_q;

endmodule

// File: tb/tb_ram8_clr.sv
// Randomized and directed bench for ram8_clr against an array-based reference model.
module tb_ram8_clr;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] in;
  logic         load;
  logic [2:0]   address;
  logic         clr;
  logic [W-1:0] out;
  logic         busy;

  ram8_clr #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in(in), .load(load),
    .address(address), .clr(clr), .out(out), .busy(busy)
  );

  always #10 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: register contents plus the index of the next register to clear.
  logic [W-1:0] m_mem [8];
  int           m_idx = -1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic l, input logic c,
                       input logic [2:0] a, input logic [W-1:0] d);
    reset = r; load = l; clr = c; address = a; in = d;
  endtask

  function automatic void model_edge();
    if (reset) begin
      for (int i = 0; i < 8; i++) m_mem[i] = '0;
      m_idx = -1;
    end else if (m_idx >= 0) begin
      m_mem[m_idx] = '0;
      m_idx = (m_idx == 7) ? -1 : m_idx + 1;
    end else if (clr) begin
      m_idx = 0;
    end else if (load) begin
      m_mem[address] = in;
    end
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("busy", 32'(busy), 32'(m_idx >= 0));
    check("out", 32'(out), 32'(m_mem[address]));
  endtask

  task automatic sweep(input string tag);
    for (int i = 0; i < 8; i++) begin
      address = 3'(i);
      #1;
      check(tag, 32'(out), 32'(m_mem[i]));
    end
  endtask

  task automatic fill(input logic [W-1:0] v);
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, 1'b0, 3'(i), v);
      step();
    end
    drive(1'b0, 1'b0, 1'b0, 3'd0, '0);
  endtask

  int cyc;

  initial begin
    for (int i = 0; i < 8; i++) m_mem[i] = 'x;
    drive(1'b1, 1'b0, 1'b0, 3'd0, '0);
    @(posedge clk); model_edge();
    step();
    drive(1'b0, 1'b0, 1'b0, 3'd0, '0);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 8; i++) begin
      address = 3'(i); #1;
      check("rst_out", 32'(out), 32'd0);
    end

    // Single write, readback and neighbour isolation
    drive(1'b0, 1'b1, 1'b0, 3'd3, 16'h1234);
    step();
    drive(1'b0, 1'b0, 1'b0, 3'd3, '0);
    #1; check("wr3", 32'(out), 32'h1234);
    address = 3'd2; #1; check("wr3_n2", 32'(out), 32'd0);

    // Distinct values at every address
    for (int n = 0; n < 8; n++) begin
      drive(1'b0, 1'b1, 1'b0, 3'(n), W'(16'hA000 + n));
      step();
    end
    drive(1'b0, 1'b0, 1'b0, 3'd0, '0);
    for (int n = 0; n < 8; n++) begin
      address = 3'(n); #1;
      check("alias", 32'(out), 32'(16'hA000 + n));
    end

    // Full clear sequence timing
    fill(16'hFFFF);
    drive(1'b0, 1'b0, 1'b1, 3'd0, '0);
    step();
    clr = 1'b0;
    check("clr_busy0", 32'(busy), 32'd1);
    for (int k = 1; k <= 8; k++) begin
      step();
      check("clr_busy", 32'(busy), 32'(k < 8));
      address = 3'(k - 1); #1;
      check("clr_k", 32'(out), 32'd0);
      if (k == 7) begin
        address = 3'd7; #1;
        check("clr_r7", 32'(out), 32'hFFFF);
      end
      sweep("clr_sweep");
    end

    // load and clr during CLEAR are ignored
    fill(16'hAAAA);
    drive(1'b0, 1'b0, 1'b1, 3'd0, '0);
    step();
    cyc = 0;
    clr = 1'b0;
    while (busy && cyc < 20) begin
      cyc++;
      if (cyc == 2) drive(1'b0, 1'b1, 1'b1, 3'd6, 16'h5555);
      else          drive(1'b0, 1'b0, 1'b0, 3'd6, '0);
      step();
    end
    check("ign_cycles", 32'(cyc), 32'd8);
    drive(1'b0, 1'b0, 1'b0, 3'd6, '0); #1;
    check("ign_r6", 32'(out), 32'd0);

    // clr has priority over load in IDLE
    drive(1'b0, 1'b1, 1'b0, 3'd0, 16'h1111);
    step();
    drive(1'b0, 1'b1, 1'b1, 3'd0, 16'h00FF);
    step();
    drive(1'b0, 1'b0, 1'b0, 3'd0, '0);
    check("prio_busy", 32'(busy), 32'd1);
    for (int k = 0; k < 8; k++) step();
    check("prio_r0", 32'(out), 32'd0);

    // Reset aborts a clear in progress
    fill(16'hBEEF);
    drive(1'b0, 1'b0, 1'b1, 3'd7, '0);
    step();
    clr = 1'b0;
    for (int k = 0; k < 4; k++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 8; i++) begin
      address = 3'(i); #1;
      check("abort_out", 32'(out), 32'd0);
    end

    // Randomized traffic
    for (int t = 0; t < 600; t++) begin
      drive(($urandom_range(0, 49) == 0), 1'($urandom),
            ($urandom_range(0, 19) == 0), 3'($urandom), W'($urandom));
      step();
      if ((t % 16) == 0) begin
        drive(1'b0, 1'b0, 1'b0, address, in);
        sweep("rnd_sweep");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
